clock_div_ctrl: RTL and testbench

Programmable clock-divider controller that generates a divided clock level and an aligned tick pulse. The divide factor is runtime-configurable through a valid/ready config port and is changed only on period boundaries, so it never produces a glitch or a runt phase. It supports a free-run mode and a counted burst mode. Consumers use it to sequence slow-clock peripherals from the single system clock.

---
 rtl/clock_div_ctrl.sv | 157 +++++++++++++++
 tb/tb_clock_div_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: programmable clock divider with a glitch-free runtime divide
// factor, free-run and counted-burst modes, and an aligned tick pulse.
module clock_div_ctrl #(
    parameter int unsigned p_width   = 8,
    parameter int unsigned p_default = 2
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               run,
    input  logic               burst_go,
    input  logic [p_width-1:0] burst_len,
    input  logic               cfg_val,
    output logic               cfg_rdy,
    input  logic [p_width-1:0] cfg_factor,
    output logic               clk_out,
    output logic               tick,
    output logic               done,
    output logic               active,
    output logic [p_width-1:0] cur_factor
);

    localparam int unsigned W = p_width;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           pending_q, pending_d;
    logic [W-1:0]   pend_factor_q, pend_factor_d;
    logic [W-1:0]   cur_factor_q, cur_factor_d;
    logic           clk_out_q, clk_out_d;
    logic           tick_q, tick_d;
    logic           done_q, done_d;

    logic           cfg_acc;
    logic           last_cnt;
    logic           apply;

    // State register; reset discards any outstanding config request.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            pending_q     <= 1'b0;
            pend_factor_q <= '0;
            cur_factor_q  <= W'(p_default);
            clk_out_q     <= 1'b0;
            tick_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            pending_q     <= pending_d;
            pend_factor_q <= pend_factor_d;
            cur_factor_q  <= cur_factor_d;
            clk_out_q     <= clk_out_d;
            tick_q        <= tick_d;
            done_q        <= done_d;
        end
    end

    // Next-state: phase counting, period-boundary decisions and config handoff.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        pending_d     = pending_q;
        pend_factor_d = pend_factor_q;
        cur_factor_d  = cur_factor_q;
        clk_out_d     = clk_out_q;
        tick_d        = 1'b0;
        done_d        = 1'b0;
        apply         = 1'b0;
        cfg_acc       = cfg_val && !pending_q;
        last_cnt      = (cnt_q == (cur_factor_q - W'(1)));

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                apply     = pending_q;
                if (burst_go) begin
                    if (burst_len != '0) begin
                        state_d   = ST_BURST;
                        clk_out_d = 1'b1;
                        rem_d     = burst_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (run) begin
                    state_d   = ST_RUN;
                    clk_out_d = 1'b1;
                end
            end
            ST_RUN, ST_BURST: begin
                if (last_cnt) begin
                    cnt_d = '0;
                    if (clk_out_q) begin
                        clk_out_d = 1'b0;
                    end else begin
                        // End of the low phase: the only point a new period may start.
                        apply = pending_q;
                        if (state_q == ST_RUN) begin
                            if (run) begin
                                clk_out_d = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            if (rem_q == W'(1)) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                rem_d     = rem_q - W'(1);
                                clk_out_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase

        if (apply) begin
            cur_factor_d = pend_factor_q;
            pending_d    = 1'b0;
        end
        // Acceptance needs !pending_q, so it never collides with an apply.
        if (cfg_acc) begin
            pending_d     = 1'b1;
            pend_factor_d = (cfg_factor == '0) ? W'(1) : cfg_factor;
        end

        tick_d = !clk_out_q && clk_out_d;
    end

    assign cfg_rdy    = !pending_q;
    assign clk_out    = clk_out_q;
    assign tick       = tick_q;
    assign done       = done_q;
    assign active     = (state_q != ST_IDLE);
    assign cur_factor = cur_factor_q;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Bench for clock_div_ctrl: directed scenarios plus random traffic against a
// period-position reference model.
module tb_clock_div_ctrl;

    localparam int unsigned W = 8;

    logic         clk_in     = 1'b0;
    logic         rst_n      = 1'b0;
    logic         run        = 1'b0;
    logic         burst_go   = 1'b0;
    logic [W-1:0] burst_len  = '0;
    logic         cfg_val    = 1'b0;
    logic [W-1:0] cfg_factor = '0;
    logic         cfg_rdy;
    logic         clk_out;
    logic         tick;
    logic         done;
    logic         active;
    logic [W-1:0] cur_factor;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: mode 0=idle 1=run 2=burst, position within a 2*f period.
    int m_mode, m_pos, m_f, m_left, m_pend, m_pf, m_done;

    clock_div_ctrl #(.p_width(W), .p_default(2)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .run        (run),
        .burst_go   (burst_go),
        .burst_len  (burst_len),
        .cfg_val    (cfg_val),
        .cfg_rdy    (cfg_rdy),
        .cfg_factor (cfg_factor),
        .clk_out    (clk_out),
        .tick       (tick),
        .done       (done),
        .active     (active),
        .cur_factor (cur_factor)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_f = 2; m_left = 0;
        m_pend = 0; m_pf = 0; m_done = 0;
    endtask

    task automatic model_edge();
        int acc;
        int nd;
        if (!rst_n) begin
            model_reset();
        end else begin
            acc = (cfg_val && m_pend == 0) ? 1 : 0;
            nd  = 0;
            if (m_mode == 0) begin
                if (m_pend != 0) begin m_f = m_pf; m_pend = 0; end
                if (burst_go) begin
                    if (burst_len != 0) begin
                        m_mode = 2; m_left = int'(burst_len); m_pos = 0;
                    end else begin
                        nd = 1;
                    end
                end else if (run) begin
                    m_mode = 1; m_pos = 0;
                end
            end else if (m_pos == 2 * m_f - 1) begin
                if (m_pend != 0) begin m_f = m_pf; m_pend = 0; end
                if (m_mode == 1) begin
                    if (run) m_pos = 0;
                    else     m_mode = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 0; nd = 1; end
                    else m_pos = 0;
                end
            end else begin
                m_pos++;
            end
            if (acc != 0) begin
                m_pend = 1;
                m_pf   = (cfg_factor == 0) ? 1 : int'(cfg_factor);
            end
            m_done = nd;
        end
    endtask

    task automatic compare_all();
        chk("clk_out",    int'(clk_out),    (m_mode != 0 && m_pos < m_f) ? 1 : 0);
        chk("tick",       int'(tick),       (m_mode != 0 && m_pos == 0) ? 1 : 0);
        chk("done",       int'(done),       m_done);
        chk("active",     int'(active),     (m_mode != 0) ? 1 : 0);
        chk("cfg_rdy",    int'(cfg_rdy),    (m_pend == 0) ? 1 : 0);
        chk("cur_factor", int'(cur_factor), m_f);
    endtask

    // One clock: model follows the edge, outputs sampled on the falling edge.
    task automatic cyc();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        compare_all();
    endtask

    initial begin
        int seq1[8];
        int seq2[6];
        int seq3[9];
        int n_act;
        int n_tick;
        int seen;
        seq1 = '{1, 1, 0, 0, 1, 1, 0, 0};
        seq2 = '{1, 1, 1, 0, 0, 0};
        seq3 = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        model_reset();

        // Reset values
        repeat (3) cyc();
        chk("rst_cur_factor", int'(cur_factor), 2);
        chk("rst_cfg_rdy", int'(cfg_rdy), 1);
        rst_n = 1'b1;
        cyc();

        // Free run at default factor 2
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t1_clk", int'(clk_out), seq1[i]);
            chk("t1_tick", int'(tick), (i == 0 || i == 4) ? 1 : 0);
            chk("t1_active", int'(active), 1);
        end

        // Factor change to 3 accepted in the second high cycle
        cyc();
        cyc();
        cfg_val = 1'b1; cfg_factor = 8'd3;
        cyc();
        cfg_val = 1'b0;
        chk("t2_rdy_a", int'(cfg_rdy), 0);
        cyc();
        chk("t2_rdy_b", int'(cfg_rdy), 0);
        chk("t2_cur_old", int'(cur_factor), 2);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t2_clk", int'(clk_out), seq2[i]);
            if (i == 0) begin
                chk("t2_cur_new", int'(cur_factor), 3);
                chk("t2_rdy_c", int'(cfg_rdy), 1);
            end
        end

        // Stop mid-high: the period completes before idling
        cyc();
        run = 1'b0;
        n_act = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (!active) break;
            n_act++;
        end
        chk("t4_tail_cycles", n_act, 5);
        chk("t4_idle_clk", int'(clk_out), 0);

        // run dropped and restored before the boundary: no gap
        run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("t4_nogap_clk", int'(clk_out), seq3[i]);
            if (i == 1) run = 1'b0;
            if (i == 3) run = 1'b1;
        end
        run = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (!active) begin seen = 1; break; end
        end
        chk("t4_drain", seen, 1);

        // Zero-length burst: immediate done, stays idle
        burst_go = 1'b1; burst_len = 8'd0;
        cyc();
        burst_go = 1'b0;
        chk("t5_zero_done", int'(done), 1);
        chk("t5_zero_active", int'(active), 0);
        cyc();
        chk("t5_zero_done_clr", int'(done), 0);

        // Config in idle back to 2, then a 3-period burst
        cfg_val = 1'b1; cfg_factor = 8'd2;
        cyc();
        cfg_val = 1'b0;
        chk("t5_idle_rdy0", int'(cfg_rdy), 0);
        cyc();
        chk("t5_idle_cur", int'(cur_factor), 2);
        chk("t5_idle_rdy1", int'(cfg_rdy), 1);
        burst_go = 1'b1; burst_len = 8'd3;
        cyc();
        burst_go = 1'b0;
        n_act = 0; n_tick = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (active) n_act++;
            if (tick) n_tick++;
            if (done) begin
                seen = 1;
                chk("t5_done_active", int'(active), 0);
                chk("t5_done_clk", int'(clk_out), 0);
                break;
            end
            cyc();
        end
        chk("t5_done_seen", seen, 1);
        chk("t5_active_cycles", n_act, 12);
        chk("t5_ticks", n_tick, 3);

        // Async reset in the middle of a burst with a pending factor
        cyc();
        burst_go = 1'b1; burst_len = 8'd4;
        cyc();
        burst_go = 1'b0;
        cfg_val = 1'b1; cfg_factor = 8'd5;
        cyc();
        cfg_val = 1'b0;
        chk("t6_pend", int'(cfg_rdy), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_clk", int'(clk_out), 0);
        chk("t6_rst_active", int'(active), 0);
        chk("t6_rst_done", int'(done), 0);
        chk("t6_rst_rdy", int'(cfg_rdy), 1);
        model_reset();
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("t6_cur_after", int'(cur_factor), 2);

        // Factor 0 stored as 1
        cfg_val = 1'b1; cfg_factor = 8'd0;
        cyc();
        cfg_val = 1'b0;
        cyc();
        chk("t7_cur1", int'(cur_factor), 1);
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t7_clk", int'(clk_out), (i % 2 == 0) ? 1 : 0);
            chk("t7_tick", int'(tick), (i % 2 == 0) ? 1 : 0);
        end
        run = 1'b0;
        repeat (4) cyc();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) run = ~run;
            burst_go  = ($urandom_range(0, 23) == 0);
            burst_len = W'($urandom_range(0, 4));
            cfg_val   = ($urandom_range(0, 7) == 0);
            cfg_factor = W'($urandom_range(0, 4));
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
